// File: rtl/cla_pkg.sv
// Shared constants, state type and sizing helpers
// for the serial carry-lookahead adder.
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_slice_4bit.sv
// Combinational 4-bit carry-lookahead slice with
// group propagate/generate outputs.
module cla_slice_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out,
  output logic       p_grp,
  output logic       g_grp
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  // Per-bit propagate/generate and lookahead carries.
  always_comb begin
    p = a ^ b;
    g = a & b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
    p_grp = &p;
    g_grp = g[3] | (p[3] & g[2])
          | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
    c_out = g_grp | (p_grp & c_in);
    s = p ^ c;
  end

endmodule

// File: rtl/cla_serial_adder.sv
// WIDTH-bit adder that streams one nibble per clock
// through a single lookahead slice, LSB first.
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             pg_all
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int CW = cnt_w(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t state;
  logic [CW-1:0] cnt;
  logic cr;
  logic pg_acc;

  logic [NSLICE-1:0][SLICE_W-1:0] a_q;
  logic [NSLICE-1:0][SLICE_W-1:0] b_q;
  logic [NSLICE-1:0][SLICE_W-1:0] sum_q;

  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_s;
  logic sl_co;
  logic sl_p;
  logic sl_g;
  logic a_msb;
  logic b_msb;

  // Select the nibble pair addressed by cnt.
  always_comb begin
    sl_a = a_q[cnt];
    sl_b = b_q[cnt];
    a_msb = a_q[NSLICE-1][SLICE_W-1];
    b_msb = b_q[NSLICE-1][SLICE_W-1];
  end

  cla_slice_4bit u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .c_in  (cr),
    .s     (sl_s),
    .c_out (sl_co),
    .p_grp (sl_p),
    .g_grp (sl_g)
  );

  // Operands are only taken while idle and out of reset.
  always_comb begin
    in_ready = (state == IDLE) && !rst;
  end

  assign sum = sum_q;

  // Sequencer: latch, walk the slices, then hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cr        <= 1'b0;
      pg_acc    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      out_valid <= 1'b0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      pg_all    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            cnt    <= '0;
            cr     <= c_in;
            pg_acc <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_q[cnt] <= sl_s;
          cr         <= sl_co;
          pg_acc     <= pg_acc & sl_p;
          if (cnt == LAST) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            c_out     <= sl_co;
            pg_all    <= pg_acc & sl_p;
            overflow  <= (a_msb == b_msb)
                      && (sl_s[SLICE_W-1] != a_msb);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_g;
  assign unused_g = sl_g;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed bench with arithmetic reference model
// and per-cycle scoreboard for cla_serial_adder.
module tb_cla_serial_adder;

  localparam int WIDTH = 16;
  localparam int NSLICE = WIDTH / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic c_in = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic in_ready;
  logic out_valid;
  logic c_out;
  logic overflow;
  logic pg_all;
  logic [15:0] sum;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] s;
    logic co;
    logic ov;
    logic pg;
    int acc;
    bit seen;
  } exp_t;

  exp_t q[$];
  int acc_log[$];
  bit prev_hs = 1'b0;

  cla_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow),
    .pg_all    (pg_all)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x,
                                 input logic [15:0] y,
                                 input logic ci,
                                 input int t);
    exp_t e;
    int ux;
    int sx;
    ux = int'(x) + int'(y) + int'(ci);
    sx = int'($signed(x)) + int'($signed(y)) + int'(ci);
    e.s = ux[15:0];
    e.co = (ux >= 65536);
    e.ov = (sx > 32767) || (sx < -32768);
    e.pg = ((x ^ y) == 16'hFFFF);
    e.acc = t;
    e.seen = 1'b0;
    return e;
  endfunction

  // Scoreboard: every cycle, check outputs and track handshakes.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("in_ready_in_rst", {31'b0, in_ready}, 0);
      q.delete();
      prev_hs = 1'b0;
    end else begin
      if (prev_hs)
        chk("valid_pulse", {31'b0, out_valid}, 0);
      if (out_valid) begin
        chk("in_ready_done", {31'b0, in_ready}, 0);
        if (q.size() == 0) begin
          chk("spurious_valid", {31'b0, out_valid}, 0);
        end else begin
          chk("sb_sum", {16'b0, sum}, {16'b0, q[0].s});
          chk("sb_cout", {31'b0, c_out}, {31'b0, q[0].co});
          chk("sb_ovf", {31'b0, overflow}, {31'b0, q[0].ov});
          chk("sb_pg", {31'b0, pg_all}, {31'b0, q[0].pg});
          if (!q[0].seen) begin
            q[0].seen = 1'b1;
            chk("latency", cyc - q[0].acc, NSLICE + 1);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_hs = out_valid && out_ready;
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, c_in, cyc));
        acc_log.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [15:0] x,
                      input logic [15:0] y,
                      input logic ci);
    int k;
    k = 0;
    a = x;
    b = y;
    c_in = ci;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("accept_wait", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic result(input string nm,
                        input logic [15:0] es,
                        input logic eco,
                        input logic eov,
                        input logic epg);
    int k;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_valid"}, {31'b0, out_valid}, 1);
    chk({nm, "_sum"}, {16'b0, sum}, {16'b0, es});
    chk({nm, "_cout"}, {31'b0, c_out}, {31'b0, eco});
    chk({nm, "_ovf"}, {31'b0, overflow}, {31'b0, eov});
    chk({nm, "_pg"}, {31'b0, pg_all}, {31'b0, epg});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    int n;
    int k;

    m = model(16'h1111, 16'h2222, 1'b0, 0);
    chk("model_pin_sum", {16'b0, m.s}, 32'h3333);
    m = model(16'h8000, 16'h8000, 1'b0, 0);
    chk("model_pin_ovf", {31'b0, m.ov}, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", {31'b0, in_ready}, 1);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_sum", {16'b0, sum}, 0);
    chk("rst_cout", {31'b0, c_out}, 0);
    chk("rst_ovf", {31'b0, overflow}, 0);
    chk("rst_pg", {31'b0, pg_all}, 0);
    @(posedge clk);
    #1;

    send(16'h1234, 16'h4321, 1'b0);
    result("t1", 16'h5555, 1'b0, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1);
    result("t2", 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0);
    result("t3", 16'h8000, 1'b0, 1'b1, 1'b0);

    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b0);
    result("bp1", 16'h5555, 1'b0, 1'b0, 1'b0);
    a = 16'h0001;
    b = 16'h0001;
    c_in = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'b0, out_valid}, 1);
      chk("bp_hold_sum", {16'b0, sum}, 32'h5555);
      chk("bp_hold_rdy", {31'b0, in_ready}, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", {31'b0, out_valid}, 1);
    chk("bp_hs_rdy", {31'b0, in_ready}, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_idle_rdy", {31'b0, in_ready}, 1);
    chk("bp_idle_valid", {31'b0, out_valid}, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    result("bp2", 16'h0002, 1'b0, 1'b0, 1'b0);

    send(16'h1234, 16'h4321, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", {31'b0, out_valid}, 0);
    chk("abort_rdy", {31'b0, in_ready}, 1);
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_result", {31'b0, out_valid}, 0);
    end
    @(posedge clk);
    #1;
    send(16'h0F0F, 16'h00F1, 1'b0);
    result("post_rst", 16'h1000, 1'b0, 1'b0, 1'b0);

    out_ready = 1'b1;
    a = 16'h1111;
    b = 16'h2222;
    c_in = 1'b0;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    a = 16'h8000;
    b = 16'h8000;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_accept2", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = acc_log.size();
    if (n >= 2)
      chk("b2b_gap", acc_log[n-1] - acc_log[n-2], NSLICE + 2);
    else
      chk("b2b_accepts", n, 2);
    result("b2b2", 16'h0000, 1'b1, 1'b1, 1'b0);

    repeat (4) @(negedge clk);
    chk("pending_results", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
